// File: rtl/qpsk_pkg.sv
`default_nettype none
// ============================================================================
// Package  : qpsk_pkg
// Brief    : Shared defaults, FSM encoding and Gray dibit-to-phase mapping for
//            the QPSK DDS modulator.
// Revision : 1.0 - initial release
// ============================================================================
package qpsk_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_LUT_AW  = 10;
    localparam int DEF_DATA_W  = 12;
    localparam int DEF_SLEN_W  = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Top three phase bits of each symbol offset: 45/135/225/315 degrees
    localparam logic [2:0] c_ofs_00 = 3'b001;
    localparam logic [2:0] c_ofs_01 = 3'b011;
    localparam logic [2:0] c_ofs_11 = 3'b101;
    localparam logic [2:0] c_ofs_10 = 3'b111;

    function automatic logic [2:0] dibit_ofs(input logic [1:0] dibit);
        logic [2:0] ofs;
        ofs = c_ofs_00;
        case (dibit)
            2'b00: ofs = c_ofs_00;
            2'b01: ofs = c_ofs_01;
            2'b11: ofs = c_ofs_11;
            2'b10: ofs = c_ofs_10;
            default: ofs = c_ofs_00;
        endcase
        return ofs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_cos_lut.sv
`default_nettype none
// ============================================================================
// Module   : dds_cos_lut
// Brief    : Quarter-wave cosine ROM with quadrant folding; two registered
//            stages from address to signed sample.
// Revision : 1.0 - initial release
// ============================================================================
module dds_cos_lut #(
    parameter int LUT_AW = 10,
    parameter int DATA_W = 12
) (
    input  logic                     dac_clk,
    input  logic                     reset_n,
    input  logic                     i_load,
    input  logic [LUT_AW-1:0]        i_addr,
    output logic signed [DATA_W-1:0] o_data
);

    localparam int  QN    = 2 ** (LUT_AW - 2);
    localparam int  MAG_W = DATA_W - 1;
    localparam real c_pi  = 3.14159265358979323846;
    localparam real c_amp = real'(2 ** (DATA_W - 1) - 1);

    logic [MAG_W-1:0]  w_rom [QN];
    logic [1:0]        w_quad;
    logic [LUT_AW-3:0] w_idx;
    logic [LUT_AW-3:0] w_fold;
    logic              w_neg;
    logic              w_zero;

    logic [MAG_W-1:0]         r_mag;
    logic                     r_neg;
    logic                     r_zero;
    logic signed [DATA_W-1:0] r_data;
    logic signed [DATA_W-1:0] w_mag_s;

    generate
        for (genvar gi = 0; gi < QN; gi++) begin : g_rom
            localparam int c_val = $rtoi(c_amp * $cos(2.0 * c_pi * real'(gi) / (4.0 * real'(QN))) + 0.5);
            assign w_rom[gi] = MAG_W'(c_val);
        end
    endgenerate

    // Odd quadrants mirror the index; their index 0 is the 90/270 degree zero crossing
    assign w_quad  = i_addr[LUT_AW-1 -: 2];
    assign w_idx   = i_addr[LUT_AW-3:0];
    assign w_fold  = w_quad[0] ? ('0 - w_idx) : w_idx;
    assign w_zero  = w_quad[0] && (w_idx == '0);
    assign w_neg   = w_quad[1] ^ w_quad[0];
    assign w_mag_s = signed'({1'b0, r_mag});

    always_ff @(posedge dac_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mag  <= '0;
            r_neg  <= 1'b0;
            r_zero <= 1'b0;
            r_data <= '0;
        end else begin
            r_mag  <= w_rom[w_fold];
            r_neg  <= w_neg;
            r_zero <= w_zero;
            if (!i_load || r_zero)
                r_data <= '0;
            else if (r_neg)
                r_data <= -w_mag_s;
            else
                r_data <= w_mag_s;
        end
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/qpsk_dds_mod.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_dds_mod
// Brief    : QPSK modulator: serial bits -> Gray dibits -> phase offset on a
//            DDS carrier; ch0 modulated cosine, ch1 reference cosine.
// Revision : 1.0 - initial release
// ============================================================================
module qpsk_dds_mod
    import qpsk_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SLEN_W  = DEF_SLEN_W
) (
    input  logic                     dac_clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [PHASE_W-1:0]       ftw,
    input  logic [SLEN_W-1:0]        sym_len,
    input  logic                     bit_data,
    input  logic                     bit_valid,
    output logic                     bit_ready,
    output logic signed [DATA_W-1:0] out_mod_data,
    output logic signed [DATA_W-1:0] out_ref_data,
    output logic                     out_valid,
    output logic                     sym_strobe,
    output logic                     underrun
);

    state_t             r_state;
    logic [SLEN_W-1:0]  r_cnt;
    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_ftw;
    logic [1:0]         r_cur;
    logic [1:0]         r_buf;
    logic               r_full;
    logic               r_half;
    logic               r_half_vld;
    logic               r_underrun;
    logic [LUT_AW-1:0]  r_mod_addr;
    logic [LUT_AW-1:0]  r_ref_addr;
    logic [1:0]         r_vld;
    logic [1:0]         r_stb;
    logic               r_out_valid;
    logic               r_sym_strobe;

    logic               w_run;
    logic               w_live;
    logic               w_bound;
    logic               w_take;
    logic               w_load;
    logic [1:0]         w_dibit;
    logic [PHASE_W-1:0] w_ftw;
    logic [PHASE_W-1:0] w_mod_phase;
    logic [SLEN_W-1:0]  w_slen_m1;

    assign w_run   = (r_state == ST_RUN);
    assign w_live  = w_run && enable;
    assign w_bound = w_live && (r_cnt == '0);
    assign w_take  = bit_valid && bit_ready;
    assign w_load  = w_live && r_vld[1];

    // The boundary sample already uses the new dibit and tuning word
    assign w_dibit     = w_bound ? (r_full ? r_buf : 2'b00) : r_cur;
    assign w_ftw       = w_bound ? ftw : r_ftw;
    assign w_mod_phase = r_acc + {dibit_ofs(w_dibit), {(PHASE_W-3){1'b0}}};
    assign w_slen_m1   = (sym_len == '0) ? '0 : sym_len - SLEN_W'(1);

    always_ff @(posedge dac_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_ftw        <= '0;
            r_cur        <= 2'b00;
            r_buf        <= 2'b00;
            r_full       <= 1'b0;
            r_half       <= 1'b0;
            r_half_vld   <= 1'b0;
            r_underrun   <= 1'b0;
            r_mod_addr   <= '0;
            r_ref_addr   <= '0;
            r_vld        <= 2'b00;
            r_stb        <= 2'b00;
            r_out_valid  <= 1'b0;
            r_sym_strobe <= 1'b0;
        end else begin
            r_state <= enable ? ST_RUN : ST_IDLE;
            if (!w_live) begin
                r_cnt        <= '0;
                r_acc        <= '0;
                r_ftw        <= '0;
                r_cur        <= 2'b00;
                r_buf        <= 2'b00;
                r_full       <= 1'b0;
                r_half       <= 1'b0;
                r_half_vld   <= 1'b0;
                r_underrun   <= 1'b0;
                r_mod_addr   <= '0;
                r_ref_addr   <= '0;
                r_vld        <= 2'b00;
                r_stb        <= 2'b00;
                r_out_valid  <= 1'b0;
                r_sym_strobe <= 1'b0;
            end else begin
                if (w_bound) begin
                    r_cnt <= w_slen_m1;
                    r_cur <= w_dibit;
                    r_ftw <= ftw;
                    if (!r_full)
                        r_underrun <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - SLEN_W'(1);
                end
                r_acc        <= r_acc + w_ftw;
                r_mod_addr   <= w_mod_phase[PHASE_W-1 -: LUT_AW];
                r_ref_addr   <= r_acc[PHASE_W-1 -: LUT_AW];
                r_vld        <= {r_vld[0], 1'b1};
                r_stb        <= {r_stb[0], w_bound};
                r_out_valid  <= r_vld[1];
                r_sym_strobe <= r_vld[1] && r_stb[1];

                // A boundary consume and a buffer write in the same cycle both land
                if (w_take) begin
                    if (r_half_vld) begin
                        r_buf      <= {r_half, bit_data};
                        r_half_vld <= 1'b0;
                    end else begin
                        r_half     <= bit_data;
                        r_half_vld <= 1'b1;
                    end
                end
                r_full <= (r_full && !w_bound) || (w_take && r_half_vld);
            end
        end
    end

    assign bit_ready  = w_run && !r_full;
    assign out_valid  = r_out_valid;
    assign sym_strobe = r_sym_strobe;
    assign underrun   = r_underrun;

    dds_cos_lut #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_lut_mod (
        .dac_clk (dac_clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_addr  (r_mod_addr),
        .o_data  (out_mod_data)
    );

    dds_cos_lut #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_lut_ref (
        .dac_clk (dac_clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_addr  (r_ref_addr),
        .o_data  (out_ref_data)
    );

endmodule
`default_nettype wire
